// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: walks (m, r, c) in row-major order, one triple per
// accepted valid/ready beat, then pulses done for one cycle.
module conv_loop_ctrl #(
  parameter int CW     = 16,
  parameter int LOOP_M = 4,
  parameter int LOOP_R = 8,
  parameter int LOOP_C = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic [CW-1:0] m_idx,
  output logic [CW-1:0] r_idx,
  output logic [CW-1:0] c_idx,
  output logic          idx_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] M_MAX = CW'(LOOP_M - 1);
  localparam logic [CW-1:0] R_MAX = CW'(LOOP_R - 1);
  localparam logic [CW-1:0] C_MAX = CW'(LOOP_C - 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_m;
  logic [CW-1:0] r_r;
  logic [CW-1:0] r_c;
  logic [CW-1:0] w_m_nx;
  logic [CW-1:0] w_r_nx;
  logic [CW-1:0] w_c_nx;
  logic          w_run;
  logic          w_acc;
  logic          w_m_end;
  logic          w_r_end;
  logic          w_c_end;
  logic          w_last;

  assign w_run   = (r_state == S_RUN);
  assign w_acc   = w_run & idx_ready;
  assign w_m_end = (r_m == M_MAX);
  assign w_r_end = (r_r == R_MAX);
  assign w_c_end = (r_c == C_MAX);
  assign w_last  = w_run & w_m_end & w_r_end & w_c_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_r     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_m     <= w_m_nx;
      r_r     <= w_r_nx;
      r_c     <= w_c_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_m_nx     = r_m;
    w_r_nx     = r_r;
    w_c_nx     = r_c;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_m_nx     = '0;
          w_r_nx     = '0;
          w_c_nx     = '0;
        end
      end
      S_RUN: begin
        // abort wins over any accepted beat, including the last one
        if (abort) begin
          w_state_nx = S_IDLE;
          w_m_nx     = '0;
          w_r_nx     = '0;
          w_c_nx     = '0;
        end else if (w_acc) begin
          unique case (1'b1)
            w_last: begin
              w_state_nx = S_DONE;
              w_m_nx     = '0;
              w_r_nx     = '0;
              w_c_nx     = '0;
            end
            w_c_end & w_r_end & ~w_m_end: begin
              w_m_nx = r_m + 1'b1;
              w_r_nx = '0;
              w_c_nx = '0;
            end
            w_c_end & ~w_r_end: begin
              w_r_nx = r_r + 1'b1;
              w_c_nx = '0;
            end
            ~w_c_end: begin
              w_c_nx = r_c + 1'b1;
            end
            default: begin
              w_state_nx = S_IDLE;
            end
          endcase
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_m_nx     = '0;
        w_r_nx     = '0;
        w_c_nx     = '0;
      end
    endcase
  end

  assign idx_valid = w_run;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign idx_last  = w_last;
  assign m_idx     = r_m;
  assign r_idx     = r_r;
  assign c_idx     = r_c;

endmodule

// File: doc/conv_loop_ctrl.md
# conv_loop_ctrl

Three-level nested loop scheduler for the convolution engine. On a start pulse it walks output-channel, row and column indices (m, r, c) in row-major order and hands one index triple per beat to the downstream datapath over a valid/ready handshake. It then pulses done and returns to idle. It sits between the layer-level control and the tile compute/address units, replacing free-running per-loop counters with one back-pressure-aware sequencer.

## Interface
- CW, 16, width of each index output; must satisfy 2^CW > max(LOOP_M, LOOP_R, LOOP_C) - 1
- LOOP_M, 4, output-channel trip count (>= 1)
- LOOP_R, 8, row trip count (>= 1)
- LOOP_C, 8, column trip count (>= 1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request to run one full loop nest; sampled only in IDLE
- abort  in  1  synchronous cancel; honoured only in RUN
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse when the last beat has been accepted
- idx_valid  out  1  index triple is valid
- idx_ready  in  1  downstream accepts the triple
- m_idx  out  CW  output-channel index
- r_idx  out  CW  row index
- c_idx  out  CW  column index
- idx_last  out  1  high with idx_valid on the final triple (m, r, c all at max)

## Operation
- States: IDLE, RUN, DONE. The FSM is registered, and all outputs are derived from registers.
- IDLE: idx_valid=0, busy=0, done=0, indices=0.
- IDLE & start=1 -> RUN. Indices load (0,0,0).
- RUN: idx_valid=1. A beat is accepted when idx_valid & idx_ready.
- On an accepted beat, indices advance:
  - c_idx increments.
  - If c_idx == LOOP_C-1, c_idx wraps to 0 and r_idx increments.
  - If r_idx is also LOOP_R-1, r_idx wraps to 0 and m_idx increments.
- No accepted beat (idx_ready=0): indices and idx_last hold stable. idx_valid stays 1; it never drops mid-run except on abort.
- idx_last = RUN & m_idx==LOOP_M-1 & r_idx==LOOP_R-1 & c_idx==LOOP_C-1.
- Accepted beat with idx_last=1 -> DONE. Indices clear to 0 and idx_valid=0.
- DONE: done=1, busy=1 for exactly one cycle, then -> IDLE unconditionally.
- start in RUN or DONE is ignored; it is not queued.
- abort in RUN -> IDLE next cycle. Indices clear, no done pulse.
  - abort has priority over a simultaneous accepted beat, including the last beat.
  - abort in IDLE or DONE has no effect.
- Total beats per run = LOOP_M*LOOP_R*LOOP_C. With all trip counts = 1, exactly one beat (0,0,0) is issued with idx_last=1.
- Index arithmetic is unsigned CW-bit. Compare with ==; no index ever exceeds its trip count minus 1.

## Timing
- Reset (rst=0, async): state=IDLE, idx_valid=0, busy=0, done=0, idx_last=0, indices=0. Release is synchronous to clk.
- Reset asserted mid-run forces IDLE immediately, with no done pulse.
- start high at edge k -> idx_valid=1 and busy=1 from cycle k+1.
- With idx_ready held high: N = LOOP_M*LOOP_R*LOOP_C beats occupy cycles k+1..k+N.
  - done=1 in cycle k+N+1.
  - IDLE in cycle k+N+2; the earliest next start is sampled there.
- Each idx_ready=0 cycle during RUN delays the remaining schedule by exactly one cycle.
- done and idx_valid are never high in the same cycle.

## Test plan
- LOOP_M=2, LOOP_R=3, LOOP_C=4, idx_ready=1, start pulse:
  - 24 consecutive beats, c fastest, first (0,0,0), last (1,2,3) with idx_last=1.
  - done exactly once, 25 cycles after start; busy high 25 cycles.
- Same config, idx_ready toggled pseudo-randomly:
  - Same 24-triple sequence with no duplicates or skips.
  - Indices stable while stalled; done one cycle after the last accepted beat.
- Trip counts all 1:
  - One beat (0,0,0) with idx_last=1, done on the next cycle, then IDLE.
- abort after 10 accepted beats, and separately abort coincident with the idx_last beat:
  - IDLE next cycle, idx_valid=0, no done pulse; a fresh start restarts at (0,0,0).
- start held high continuously:
  - Back-to-back runs separated by DONE plus one IDLE cycle. start during RUN does not restart or corrupt indices.
- rst=0 asserted at beat 7 (async, mid-cycle):
  - All outputs immediately at reset values. After release and start, the sequence restarts from (0,0,0).
